// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: ID/EX control decode register with halt-drain FSM and error squash
module ctrl_decode_pipe #(
  parameter int INSTR_W    = 16,
  parameter int DRAIN      = 3,
  parameter bit ERR_STICKY = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               flush,
  input  logic               err_in,
  output logic               id_ready,
  output logic               ex_valid,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_jr,
  output logic               ex_imm_use,
  output logic [1:0]         ex_branch_choose,
  output logic [3:0]         ex_aluop,
  output logic               halted,
  output logic               err_out
);
  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jr;
    logic       imm_use;
    logic [1:0] choose;
    logic [3:0] aluop;
  } ex_t;
  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;
  state_t     state, state_nx;
  logic [2:0] cnt, cnt_nx;
  ex_t        ex, ex_nx, dec;
  logic       err, err_nx;
  logic [4:0] op;
  logic [1:0] func;
  logic       is_reg, capture, halt_cap;
  logic       unused_instr;
  assign op           = instr[INSTR_W-1 -: 5];
  assign func         = instr[1:0];
  assign unused_instr = ^instr[INSTR_W-6:2];
  assign is_reg       = op[4] & op[3];
  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.jump      = op[4:2] == 3'b001;
    dec.jr        = dec.jump & op[0];
    dec.branch    = op[4:2] == 3'b011;
    dec.choose    = dec.branch ? op[1:0] : 2'b00;
    dec.mem_read  = op == OP_LD;
    dec.mem_write = (op == OP_ST) | (op == OP_STU);
    dec.reg_write = is_reg | (op[4:2] == 3'b010) | (op == OP_LD) | (op == OP_STU);
    dec.imm_use   = ~op[4] | ~op[3];
    dec.aluop     = is_reg ? {op[4] & op[3] & ~op[2] & ~op[1] & op[0], op[2],
                              op[1] ^ func[1], op[0] ^ func[0]} : 4'b0000;
  end
  assign id_ready = (state == S_RUN) & ~err;
  assign capture  = id_ready & id_valid & ~stall;
  // a HALT that is squashed or arrives with an error never starts a drain
  assign halt_cap = capture & ~flush & ~err_in & (op == OP_HALT);
  // errors and flushes beat stall so nothing stale survives into EX
  assign ex_nx  = (err_in | err | flush) ? '0 : stall ? ex : capture ? dec : '0;
  assign err_nx = ERR_STICKY ? (err | err_in) : err_in;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_RUN: begin
        state_nx = halt_cap ? S_DRAIN : S_RUN;
        cnt_nx   = halt_cap ? 3'(DRAIN) : cnt;
      end
      S_DRAIN: begin
        state_nx = flush ? S_RUN : (~stall && cnt == 3'd1) ? S_HALTED : S_DRAIN;
        cnt_nx   = flush ? 3'd0 : stall ? cnt : cnt - 3'd1;
      end
      S_HALTED: state_nx = S_HALTED;
      default: begin
        state_nx = S_RUN;
        cnt_nx   = 3'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_RUN;
      cnt   <= 3'd0;
      ex    <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ex    <= ex_nx;
      err   <= err_nx;
    end
  end
  assign ex_valid         = ex.valid;
  assign ex_reg_write     = ex.reg_write;
  assign ex_mem_read      = ex.mem_read;
  assign ex_mem_write     = ex.mem_write;
  assign ex_branch        = ex.branch;
  assign ex_jump          = ex.jump;
  assign ex_jr            = ex.jr;
  assign ex_imm_use       = ex.imm_use;
  assign ex_branch_choose = ex.choose;
  assign ex_aluop         = ex.aluop;
  assign halted           = state == S_HALTED;
  assign err_out          = err;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: directed + randomized checks against a cycle-level reference model
module tb_ctrl_decode_pipe;
  localparam int DRAIN_N = 3;
  logic        clk = 1'b0, rst = 1'b0;
  logic        id_valid = 1'b0, stall = 1'b0, flush = 1'b0, err_in = 1'b0;
  logic [15:0] instr = '0;
  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_jr, ex_imm_use, halted, err_out;
  logic [1:0]  ex_branch_choose;
  logic [3:0]  ex_aluop;
  logic [13:0] ex_obs;
  int checks = 0, failures = 0;
  int m_mode, m_left;
  bit m_err;
  logic [13:0] m_ex;

  ctrl_decode_pipe #(.INSTR_W(16), .DRAIN(DRAIN_N), .ERR_STICKY(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr), .stall(stall),
    .flush(flush), .err_in(err_in), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jr(ex_jr), .ex_imm_use(ex_imm_use),
    .ex_branch_choose(ex_branch_choose), .ex_aluop(ex_aluop), .halted(halted),
    .err_out(err_out)
  );

  always #5 clk = ~clk;
  assign ex_obs = {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump,
                   ex_jr, ex_imm_use, ex_branch_choose, ex_aluop};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // opcode classes by numeric range: 4..7 jump, 8..11 reg, 12..15 branch, 24..31 register ALU
  function automatic logic [13:0] ref_dec(input logic [15:0] w);
    int op, f, ch, alu;
    bit rw, mr, mw, br, jp, jr, imm;
    op  = int'(w[15:11]);
    f   = int'(w[1:0]);
    jp  = op >= 4 && op < 8;
    jr  = jp && (op % 2 == 1);
    br  = op >= 12 && op < 16;
    ch  = br ? op % 4 : 0;
    mr  = op == 17;
    mw  = op == 16 || op == 19;
    rw  = op >= 24 || (op >= 8 && op < 12) || op == 17 || op == 19;
    imm = op < 24;
    alu = 0;
    if (op >= 24)
      alu = (op == 25 ? 8 : 0) + ((op / 4) % 2) * 4 + (((op / 2) % 2) ^ (f / 2)) * 2 + ((op % 2) ^ (f % 2));
    return {1'b1, rw, mr, mw, br, jp, jr, imm, 2'(ch), 4'(alu)};
  endfunction

  task automatic cyc(input bit v, input logic [15:0] w, input bit s, input bit fl, input bit e);
    bit ready, cap;
    id_valid = v; instr = w; stall = s; flush = fl; err_in = e;
    ready = (m_mode == 0) && !m_err;
    #1 check("id_ready", id_ready, ready);
    cap = ready && v && !s;
    if (e || m_err || fl) m_ex = '0;
    else if (!s) m_ex = cap ? ref_dec(w) : '0;
    if (m_mode == 0) begin
      if (cap && !fl && !e && w[15:11] == 5'd0) begin m_mode = 1; m_left = DRAIN_N; end
    end else if (m_mode == 1) begin
      if (fl) m_mode = 0;
      else if (!s) begin m_left--; if (m_left == 0) m_mode = 2; end
    end
    m_err = m_err || e;
    @(posedge clk); #1;
    check("ex", ex_obs, m_ex);
    check("halted", halted, m_mode == 2);
    check("err_out", err_out, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b0; id_valid = 0; stall = 0; flush = 0; err_in = 0;
    m_mode = 0; m_left = 0; m_err = 0; m_ex = '0;
    @(posedge clk); #1;
    check("rst_ex", ex_obs, 0);
    check("rst_halted", halted, 0);
    check("rst_err", err_out, 0);
    rst = 1'b1;
    #1 check("rst_ready", id_ready, 1);
  endtask

  function automatic logic [15:0] mk(input logic [4:0] op);
    logic [15:0] w;
    w = 16'($urandom);
    w[15:11] = op;
    return w;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    do_reset();
    cyc(1, mk(5'b10001), 0, 0, 0);
    check("ld_mem_read", ex_mem_read, 1);
    check("ld_reg_write", ex_reg_write, 1);
    check("ld_mem_write", ex_mem_write, 0);
    cyc(1, mk(5'b01101), 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, mk(5'b10000), 1, 0, 0);
      check("br_hold", {ex_valid, ex_branch, ex_branch_choose}, 4'b1101);
    end
    cyc(1, mk(5'b10000), 1, 1, 0);
    check("flush_over_stall", ex_valid, 0);
    cyc(1, mk(5'b00000), 0, 0, 0);
    check("halt_ready", id_ready, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1, mk(5'b11000), 0, 0, 0);
      check("halt_timing", halted, i == 3);
    end
    cyc(1, mk(5'b11000), 0, 0, 0);
    check("halt_terminal", halted, 1);
    do_reset();
    cyc(1, mk(5'b00000), 0, 0, 0);
    cyc(0, 16'h0, 0, 0, 0);
    cyc(0, 16'h0, 0, 1, 0);
    check("drain_flush_ready", id_ready, 1);
    for (int i = 0; i < 5; i++) cyc(1, mk(5'(8 + i)), 0, 0, 0);
    cyc(1, mk(5'b00000), 0, 0, 0);
    cyc(0, 16'h0, 1, 0, 0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit v, s, fl, e;
      logic [4:0] op;
      if ($urandom_range(0, 59) == 0 || ((m_mode == 2 || m_err) && $urandom_range(0, 7) == 0))
        do_reset();
      v  = $urandom_range(0, 3) != 0;
      op = ($urandom_range(0, 11) == 0) ? 5'd0 : 5'($urandom);
      s  = $urandom_range(0, 4) == 0;
      fl = $urandom_range(0, 9) == 0;
      e  = $urandom_range(0, 149) == 0;
      cyc(v, mk(op), s, fl, e);
    end
    do_reset();
    cyc(1, mk(5'b11000), 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, mk(5'($urandom_range(16, 31))), 0, 0, 0);
      check("err_sticky", err_out, 1);
      check("err_no_write", {ex_reg_write, ex_mem_write}, 0);
    end
    do_reset();
    check("err_cleared", err_out, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ctrl_decode_pipe.md
CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

Interface
REQ-001 Parameter INSTR_W, 16, instruction width; opcode is instr[INSTR_W-1 -: 5]; func bits are instr[1:0].
REQ-002 Parameter DRAIN, 3, number of downstream stages to drain after HALT before reporting halted; range 1..7.
REQ-003 Parameter ERR_STICKY, 1, when 1 err_out holds until reset; when 0 err_out follows err_in registered.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 id_valid  input  1  instr carries a valid decoded-stage instruction this cycle.
REQ-007 instr  input  INSTR_W  instruction word.
REQ-008 stall  input  1  hold ID/EX register contents; do not accept new instr.
REQ-009 flush  input  1  squash instruction currently being captured (branch mispredict).
REQ-010 err_in  input  1  error flagged elsewhere in pipe.
REQ-011 id_ready  output  1  block accepts instr this cycle.
REQ-012 ex_valid  output  1  ID/EX register holds a live instruction.
REQ-013 ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_jr, ex_imm_use  output  1 each  registered control bits.
REQ-014 ex_branch_choose  output  2  registered opcode[1:0] for branches.
REQ-015 ex_aluop  output  4  registered ALU opcode.
REQ-016 halted  output  1  processor fully halted.
REQ-017 err_out  output  1  registered error indication.

Function
REQ-018 Decode: HALT=00000, NOP=00001; jump class 001xx (opcode[0]=1 -> JR); branch class 011xx; LD=10001; ST=10000; STU=10011; all 11xxx and 010xx write a register; STU and LD write a register.
REQ-019 Decode: ex_imm_use = ~op[4] | ~op[3]; ex_aluop = {op[4]&op[3]&~op[2]&~op[1]&op[0], op[2], op[1]^func[1], op[0]^func[0]} for register-class, 4'b0000 (add) otherwise.
REQ-020 Capture occurs when id_ready & id_valid & ~stall; captured bits appear on ex_* next cycle (latency 1).
REQ-021 HALT and NOP capture with all write/branch/jump controls 0 and ex_valid=1.
REQ-022 flush in a capture cycle loads a bubble: ex_valid=0, all ex_* controls 0; flush has priority over stall.
REQ-023 stall without flush holds every ex_* output unchanged.
REQ-024 Cycle with no capture (id_valid=0, no stall) loads a bubble.
REQ-025 FSM states RUN, DRAIN, HALTED; reset state RUN.
REQ-026 RUN -> DRAIN when HALT captured; drain counter loads DRAIN.
REQ-027 DRAIN: id_ready=0; counter decrements each cycle stall=0; held while stall=1; flush in DRAIN returns to RUN (halt was speculative).
REQ-028 DRAIN -> HALTED when counter reaches 0; HALTED is terminal until reset; halted=1 only in HALTED.
REQ-029 In DRAIN and HALTED, capture is blocked and bubbles are loaded.
REQ-030 err_in=1 forces bubble load (writes suppressed) from next cycle; err_out asserted next cycle, sticky per ERR_STICKY.
REQ-031 id_ready = (state==RUN) & ~err_out.

Reset
REQ-032 rst=0 at a rising edge: state RUN, counter 0, ex_valid 0, all ex_* 0, halted 0, err_out 0, regardless of in-progress drain or stall.
REQ-033 id_ready=1 in the first cycle after rst deasserts.

Verification
REQ-034 Capture LD (opcode 10001) with stall=0 -> next cycle ex_valid=1, ex_mem_read=1, ex_reg_write=1, ex_mem_write=0.
REQ-035 Capture branch 01101 then stall=1 for 3 cycles -> ex_branch=1, ex_branch_choose=01 held all 3 cycles.
REQ-036 HALT captured, DRAIN=3, stall=0 -> id_ready=0 from next cycle; halted=1 exactly 4 cycles after capture.
REQ-037 HALT captured, flush on 2nd DRAIN cycle -> state RUN, halted never asserts, id_ready=1 next cycle.
REQ-038 err_in pulse 1 cycle with ERR_STICKY=1 -> err_out=1 until rst=0, ex_reg_write=0, ex_mem_write=0 throughout.
REQ-039 rst=0 during DRAIN -> all outputs 0 next cycle, id_ready=1 after release.
